// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller: cell codes, FSM states,
// the eight winning lines and small helpers for the flat 9-cell board vector.
// Board layout: cell k (0-based, row-major) occupies bits [2k+1:2k].
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic [1:0] CELL_DRAW  = 2'b11;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // 0-based cell indices of every line: 3 rows, 3 columns, 2 diagonals
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Fetch one 2-bit cell; out-of-range indices read as empty
  function automatic logic [1:0] cell_of(input logic [17:0] cells, input logic [3:0] idx);
    logic [1:0] v;
    v = CELL_EMPTY;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (idx == k[3:0]) v = cells[2*k +: 2];
    end
    return v;
  endfunction

  // X <-> O; anything else maps to X so a bad value cannot stick
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_X) ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational win detector: scans all eight lines of the board and reports
// the owner of the first fully-owned line (00 when nobody has a line).
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [17:0] i_cells,
  output logic [1:0]  o_winner
);

  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [1:0] w_c;

  // Three equal, non-empty cells on any line give the winner
  always_comb begin
    o_winner = CELL_EMPTY;
    w_a      = CELL_EMPTY;
    w_b      = CELL_EMPTY;
    w_c      = CELL_EMPTY;
    for (int l = 0; l < NUM_LINES; l++) begin
      w_a = cell_of(i_cells, WIN_LINES[l][0]);
      w_b = cell_of(i_cells, WIN_LINES[l][1]);
      w_c = cell_of(i_cells, WIN_LINES[l][2]);
      if ((o_winner == CELL_EMPTY) && (w_a != CELL_EMPTY) && (w_a == w_b) && (w_a == w_c)) begin
        o_winner = w_a;
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencing controller. Edge-detects the commit button and the
// new-game input, validates each move, writes the board, alternates turns and
// freezes the board on a win or draw. All outputs are registered.
//
// Input protocol: i_move_btn and i_new_game are levels already synchronised to
// i_clock. Only a 0->1 transition seen at a rising edge acts (one action per
// press, however long it is held). i_move_sel is looked at only on the edge
// where the button pulse is seen; a pulse arriving while the FSM is in CHECK or
// OVER is discarded, never queued. A new-game pulse beats a move pulse on the
// same edge, and i_reset beats both.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER    = 2'b01,
  parameter bit         ALTERNATE_START = 1'b1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_move_btn,
  input  logic [3:0] i_move_sel,
  input  logic       i_new_game,
  output logic [1:0] o_pos1,
  output logic [1:0] o_pos2,
  output logic [1:0] o_pos3,
  output logic [1:0] o_pos4,
  output logic [1:0] o_pos5,
  output logic [1:0] o_pos6,
  output logic [1:0] o_pos7,
  output logic [1:0] o_pos8,
  output logic [1:0] o_pos9,
  output logic [1:0] o_who,
  output logic       o_ill,
  output logic       o_game_over,
  output logic [1:0] o_state
);

  state_t      r_state;
  logic        r_btn_q;
  logic        r_new_q;
  logic [17:0] r_board;
  logic [1:0]  r_who;
  logic [1:0]  r_starter;
  logic        r_ill;
  logic        r_over;
  logic [3:0]  r_count;

  logic        w_move_pulse;
  logic        w_new_pulse;
  logic        w_sel_ok;
  logic [1:0]  w_sel_cell;
  logic [1:0]  w_winner;
  logic [1:0]  w_next_starter;

  assign w_move_pulse   = i_move_btn & ~r_btn_q;
  assign w_new_pulse    = i_new_game & ~r_new_q;
  assign w_sel_ok       = (i_move_sel >= 4'd1) && (i_move_sel <= 4'd9);
  assign w_sel_cell     = cell_of(r_board, i_move_sel - 4'd1);
  assign w_next_starter = ALTERNATE_START ? other_player(r_starter) : FIRST_PLAYER;

  // Win detection always looks at the registered board
  ttt_win_detect u_win_detect (
    .i_cells  (r_board),
    .o_winner (w_winner)
  );

  // Game FSM with board, counter, edge detectors and starter tracking
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_PLAY;
      r_btn_q   <= 1'b0;
      r_new_q   <= 1'b0;
      r_board   <= '0;
      r_who     <= FIRST_PLAYER;
      r_starter <= FIRST_PLAYER;
      r_ill     <= 1'b0;
      r_over    <= 1'b0;
      r_count   <= 4'd0;
    end else begin
      r_btn_q <= i_move_btn;
      r_new_q <= i_new_game;
      if (w_new_pulse) begin
        r_state   <= ST_PLAY;
        r_board   <= '0;
        r_who     <= w_next_starter;
        r_starter <= w_next_starter;
        r_ill     <= 1'b0;
        r_over    <= 1'b0;
        r_count   <= 4'd0;
      end else begin
        case (r_state)
          ST_PLAY: begin
            if (w_move_pulse) begin
              if (w_sel_ok && (w_sel_cell == CELL_EMPTY)) begin
                for (int k = 0; k < NUM_CELLS; k++) begin
                  if (i_move_sel == 4'(k + 1)) r_board[2*k +: 2] <= r_who;
                end
                r_count <= r_count + 4'd1;
                r_ill   <= 1'b0;
                r_state <= ST_CHECK;
              end else begin
                r_ill <= 1'b1;
              end
            end
          end
          ST_CHECK: begin
            // A win is checked before the draw so a 9th-move win counts as a win
            if (w_winner != CELL_EMPTY) begin
              r_who   <= w_winner;
              r_over  <= 1'b1;
              r_state <= ST_OVER;
            end else if (r_count == 4'd9) begin
              r_who   <= CELL_DRAW;
              r_over  <= 1'b1;
              r_state <= ST_OVER;
            end else begin
              r_who   <= other_player(r_who);
              r_state <= ST_PLAY;
            end
          end
          ST_OVER: begin
            r_state <= ST_OVER;
          end
          default: begin
            r_state <= ST_PLAY;
          end
        endcase
      end
    end
  end

  assign o_pos1      = r_board[1:0];
  assign o_pos2      = r_board[3:2];
  assign o_pos3      = r_board[5:4];
  assign o_pos4      = r_board[7:6];
  assign o_pos5      = r_board[9:8];
  assign o_pos6      = r_board[11:10];
  assign o_pos7      = r_board[13:12];
  assign o_pos8      = r_board[15:14];
  assign o_pos9      = r_board[17:16];
  assign o_who       = r_who;
  assign o_ill       = r_ill;
  assign o_game_over = r_over;
  assign o_state     = r_state;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl. The driver issues directed moves and
// pushes hand-computed expected snapshots {board, who, ill, game_over, state};
// a monitor pops and compares them on the falling edge whenever a sample is
// requested.
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  localparam int W = 24;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_move_btn = 1'b0;
  logic [3:0] i_move_sel = 4'd0;
  logic       i_new_game = 1'b0;
  logic [1:0] o_pos1, o_pos2, o_pos3, o_pos4, o_pos5, o_pos6, o_pos7, o_pos8, o_pos9;
  logic [1:0] o_who;
  logic       o_ill;
  logic       o_game_over;
  logic [1:0] o_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         r_sample = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] m_exp;
  logic [W-1:0] m_act;
  string        m_name;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  ttt_game_ctrl #(
    .FIRST_PLAYER    (2'b01),
    .ALTERNATE_START (1'b1)
  ) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_move_btn  (i_move_btn),
    .i_move_sel  (i_move_sel),
    .i_new_game  (i_new_game),
    .o_pos1      (o_pos1),
    .o_pos2      (o_pos2),
    .o_pos3      (o_pos3),
    .o_pos4      (o_pos4),
    .o_pos5      (o_pos5),
    .o_pos6      (o_pos6),
    .o_pos7      (o_pos7),
    .o_pos8      (o_pos8),
    .o_pos9      (o_pos9),
    .o_who       (o_who),
    .o_ill       (o_ill),
    .o_game_over (o_game_over),
    .o_state     (o_state)
  );

  // Board string, cell 1 first: 'X', 'O' or '.'
  function automatic logic [17:0] mk_board(input string s);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      if (s[i] == "X")      b[2*i +: 2] = 2'b01;
      else if (s[i] == "O") b[2*i +: 2] = 2'b10;
    end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One rising button edge; the pulse is taken on the first clock edge
  task automatic pulse_move(input int sel);
    i_move_sel = 4'(sel);
    i_move_btn = 1'b1;
    tick();
    i_move_btn = 1'b0;
  endtask

  // Legal move followed by its CHECK cycle
  task automatic move(input int sel);
    pulse_move(sel);
    tick();
  endtask

  task automatic new_game();
    i_new_game = 1'b1;
    tick();
    i_new_game = 1'b0;
    tick();
  endtask

  task automatic chk(input string name, input string brd, input logic [1:0] who,
                     input logic ill, input logic over, input logic [1:0] st);
    exp_q.push_back({mk_board(brd), who, ill, over, st});
    name_q.push_back(name);
    r_sample = 1'b1;
    @(negedge clk);
    #1;
    r_sample = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Compare the DUT snapshot against the oldest expectation on each requested sample
  always @(negedge clk) begin
    if (r_sample) begin
      n_checks++;
      m_act = {o_pos9, o_pos8, o_pos7, o_pos6, o_pos5, o_pos4, o_pos3, o_pos2, o_pos1,
               o_who, o_ill, o_game_over, o_state};
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL no_expectation: got %h, required an expected entry", m_act);
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        if (m_act !== m_exp) begin
          n_errors++;
          $display("FAIL %s: got board=%h who=%b ill=%b over=%b st=%0d, required board=%h who=%b ill=%b over=%b st=%0d",
                   m_name, m_act[23:6], m_act[5:4], m_act[3], m_act[2], m_act[1:0],
                   m_exp[23:6], m_exp[5:4], m_exp[3], m_exp[2], m_exp[1:0]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int draw_seq[8];
    int diag_seq[8];
    draw_seq = '{1, 2, 3, 5, 4, 6, 8, 7};
    diag_seq = '{1, 2, 3, 4, 5, 6, 8, 7};

    repeat (2) tick();
    i_reset = 1'b0;
    chk("reset", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);

    // X wins the top row
    move(1); chk("t1_x1", "X........", 2'b10, 1'b0, 1'b0, ST_PLAY);
    move(4); chk("t1_o4", "X..O.....", 2'b01, 1'b0, 1'b0, ST_PLAY);
    move(2); chk("t1_x2", "XX.O.....", 2'b10, 1'b0, 1'b0, ST_PLAY);
    move(5); chk("t1_o5", "XX.OO....", 2'b01, 1'b0, 1'b0, ST_PLAY);
    pulse_move(3);
    chk("t1_x3_check", "XXXOO....", 2'b01, 1'b0, 1'b0, ST_CHECK);
    tick();
    chk("t1_win", "XXXOO....", 2'b01, 1'b0, 1'b1, ST_OVER);
    move(9); chk("t1_over_ignored", "XXXOO....", 2'b01, 1'b0, 1'b1, ST_OVER);

    // Starter alternates each new game
    new_game(); chk("ng_alt_o", ".........", 2'b10, 1'b0, 1'b0, ST_PLAY);
    new_game(); chk("ng_alt_x", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);

    // Occupied cell
    move(5); chk("t2_x5", "....X....", 2'b10, 1'b0, 1'b0, ST_PLAY);
    pulse_move(5);
    chk("t2_o5_ill", "....X....", 2'b10, 1'b1, 1'b0, ST_PLAY);
    tick();
    chk("t2_ill_hold", "....X....", 2'b10, 1'b1, 1'b0, ST_PLAY);
    pulse_move(1);
    chk("t2_o1_check", "O...X....", 2'b10, 1'b0, 1'b0, ST_CHECK);
    tick();
    chk("t2_o1", "O...X....", 2'b01, 1'b0, 1'b0, ST_PLAY);

    // Out-of-range selectors (O to move)
    new_game(); chk("ng_g4", ".........", 2'b10, 1'b0, 1'b0, ST_PLAY);
    pulse_move(0);  chk("t3_sel0",  ".........", 2'b10, 1'b1, 1'b0, ST_PLAY); tick();
    pulse_move(12); chk("t3_sel12", ".........", 2'b10, 1'b1, 1'b0, ST_PLAY); tick();
    pulse_move(10); chk("t3_sel10", ".........", 2'b10, 1'b1, 1'b0, ST_PLAY); tick();

    // Draw; illegal attempts first must not advance the move count
    new_game(); chk("ng_g5", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);
    pulse_move(15); chk("t4_sel15", ".........", 2'b01, 1'b1, 1'b0, ST_PLAY); tick();
    move(draw_seq[0]);
    chk("t4_first", "X........", 2'b10, 1'b0, 1'b0, ST_PLAY);
    for (int i = 1; i < 8; i++) move(draw_seq[i]);
    chk("t4_eight", "XOXXOOOX.", 2'b01, 1'b0, 1'b0, ST_PLAY);
    pulse_move(9);
    chk("t4_ninth_check", "XOXXOOOXX", 2'b01, 1'b0, 1'b0, ST_CHECK);
    tick();
    chk("t4_draw", "XOXXOOOXX", 2'b11, 1'b0, 1'b1, ST_OVER);
    move(5); chk("t4_frozen", "XOXXOOOXX", 2'b11, 1'b0, 1'b1, ST_OVER);

    // Ninth move completes X's 1-5-9 diagonal
    new_game();
    new_game(); chk("ng_g7", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);
    for (int i = 0; i < 8; i++) move(diag_seq[i]);
    chk("t5_eight", "XOXOXOOX.", 2'b01, 1'b0, 1'b0, ST_PLAY);
    pulse_move(9);
    chk("t5_ninth_check", "XOXOXOOXX", 2'b01, 1'b0, 1'b0, ST_CHECK);
    tick();
    chk("t5_diag_win", "XOXOXOOXX", 2'b01, 1'b0, 1'b1, ST_OVER);

    // Held button: one move only (O starts this game)
    new_game();
    i_move_sel = 4'd3;
    i_move_btn = 1'b1;
    repeat (20) tick();
    i_move_btn = 1'b0;
    tick();
    chk("t6_held", "..O......", 2'b01, 1'b0, 1'b0, ST_PLAY);

    // new_game and move on the same edge: move discarded, X starts
    i_new_game = 1'b1;
    i_move_btn = 1'b1;
    i_move_sel = 4'd5;
    tick();
    i_new_game = 1'b0;
    i_move_btn = 1'b0;
    chk("t6_ng_and_move", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);
    tick();
    chk("t6_move_dropped", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);

    // Reset mid-game with ill set
    move(1); chk("t6_pre_reset", "X........", 2'b10, 1'b0, 1'b0, ST_PLAY);
    pulse_move(1); tick();
    i_reset = 1'b1;
    tick();
    chk("t6_reset", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);
    i_reset = 1'b0;
    tick();
    new_game(); chk("reset_starter", ".........", 2'b10, 1'b0, 1'b0, ST_PLAY);

    // new_game arriving during CHECK wins over the pending turn change
    pulse_move(5);
    i_new_game = 1'b1;
    tick();
    i_new_game = 1'b0;
    chk("ng_in_check", ".........", 2'b01, 1'b0, 1'b0, ST_PLAY);

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      n_errors += exp_q.size();
      $display("FAIL leftover_expectations: got %0d unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
